// File: rtl/memory_access_pkg.sv
// Shared Y86-64 constants, M-register layout and access-decoding helpers
// for the memory stage.
package memory_access_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {StIdle, StWait, StDone} mem_state_e;

    typedef enum logic [1:0] {AccNone, AccRead, AccWrite} acc_kind_e;

    typedef struct packed {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } m_reg_t;

    localparam m_reg_t MRegBubble = '{
        icode: INOP, stat: SAOK, val_e: 64'd0, val_a: 64'd0, dst_e: RNONE, dst_m: RNONE
    };

    function automatic acc_kind_e acc_kind(input logic [3:0] icode);
        acc_kind_e kind;
        case (icode)
            IMRMOVQ, IPOPQ, IRET:  kind = AccRead;
            IRMMOVQ, IPUSHQ, ICALL: kind = AccWrite;
            default:               kind = AccNone;
        endcase
        return kind;
    endfunction

    // Pops and returns read from the old stack pointer carried in valA.
    function automatic logic [63:0] acc_addr(input logic [3:0] icode,
                                             input logic [63:0] val_e,
                                             input logic [63:0] val_a);
        return (icode == IPOPQ || icode == IRET) ? val_a : val_e;
    endfunction

endpackage

// File: rtl/memory_access_pipe_reg.sv
// E->M pipeline register: reset/bubble load the nop, an outstanding access
// holds it regardless of stall/bubble.
module mem_pipe_reg
    import memory_access_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   busy_i,
    input  logic   stall_i,
    input  logic   bubble_i,
    input  m_reg_t d_i,
    output m_reg_t q_o
);

    m_reg_t m_d, m_q;

    always_comb begin
        m_d = m_q;
        if (busy_i) begin
            m_d = m_q;
        end else if (bubble_i) begin
            m_d = MRegBubble;
        end else if (!stall_i) begin
            m_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q <= MRegBubble;
        end else begin
            m_q <= m_d;
        end
    end

    assign q_o = m_q;

endmodule

// File: rtl/memory_access.sv
// Y86-64 memory stage: M register, single req/ack data access per
// instruction with bounds fault, bus error and timeout reporting.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned MEM_BYTES      = 8192,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memory_stall_i,
    input  logic        memory_bubble_i,
    input  logic [3:0]  icode_i,
    input  logic [2:0]  stat_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [3:0]  dstE_i,
    input  logic [3:0]  dstM_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic        dmem_err_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        mem_busy_o,
    output logic [3:0]  icode_o,
    output logic [63:0] valE_o,
    output logic [63:0] valM_o,
    output logic [3:0]  dstE_o,
    output logic [3:0]  dstM_o,
    output logic [2:0]  stat_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [63:0] AddrMax = 64'(MEM_BYTES - 8);

    mem_state_e      state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic [63:0]     val_m_d, val_m_q;
    logic            mem_err_d, mem_err_q;
    m_reg_t          e_in, m_q;
    logic            busy;
    logic            in_has_acc, in_oob, load, issue, timeout;

    assign busy = (state_q == StWait);

    assign e_in = '{
        icode: icode_i, stat: stat_i, val_e: valE_i, val_a: valA_i, dst_e: dstE_i, dst_m: dstM_i
    };

    mem_pipe_reg u_mem_pipe_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .busy_i   (busy),
        .stall_i  (memory_stall_i),
        .bubble_i (memory_bubble_i),
        .d_i      (e_in),
        .q_o      (m_q)
    );

    // Classify the incoming instruction so the access starts the cycle it lands in M.
    assign in_has_acc = (acc_kind(icode_i) != AccNone) && (stat_i == SAOK);
    assign in_oob     = acc_addr(icode_i, valE_i, valA_i) > AddrMax;
    assign load       = !busy && !memory_bubble_i && !memory_stall_i;
    assign issue      = load && in_has_acc && !in_oob;
    assign timeout    = (cnt_q == CntLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            val_m_q   <= 64'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            val_m_q   <= val_m_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: state_d = issue ? StWait : StIdle;
            StWait:         if (dmem_ack_i || timeout) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        val_m_d   = val_m_q;
        mem_err_d = mem_err_q;
        if (busy) begin
            if (dmem_ack_i) begin
                mem_err_d = dmem_err_i;
                if (acc_kind(m_q.icode) == AccRead) val_m_d = dmem_rdata_i;
            end else if (timeout) begin
                mem_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            // A stalled instruction keeps whatever fault it already reported.
            if (memory_bubble_i) begin
                mem_err_d = 1'b0;
            end else if (!memory_stall_i) begin
                mem_err_d = in_has_acc && in_oob;
            end
            if (issue) cnt_d = '0;
        end
    end

    always_comb begin
        dmem_req_o   = busy;
        mem_busy_o   = busy;
        dmem_we_o    = (acc_kind(m_q.icode) == AccWrite);
        dmem_addr_o  = acc_addr(m_q.icode, m_q.val_e, m_q.val_a);
        dmem_wdata_o = m_q.val_a;
        icode_o      = m_q.icode;
        valE_o       = m_q.val_e;
        valM_o       = val_m_q;
        dstE_o       = m_q.dst_e;
        dstM_o       = m_q.dst_m;
        stat_o       = mem_err_q ? SADR : m_q.stat;
    end

endmodule
